pic_interrupt_controller: RTL and testbench

// - Control core of the 8259A PIC: latches IR requests, masks, resolves priority (fixed/rotating),

---
 rtl/pic_interrupt_controller_pkg.sv | 31 +++
 rtl/pic_interrupt_controller_resolver.sv | 27 ++
 rtl/pic_interrupt_controller.sv | 159 +++++++++++++++
 tb/tb_pic_interrupt_controller.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pic_interrupt_controller_pkg.sv
// Shared types and encodings for the PIC control core: acknowledge states,
// OCW2 command codes, control-word field positions and a priority-rank helper.
package pic_interrupt_controller_pkg;

  typedef enum logic [1:0] {
    ACK_IDLE = 2'd0,
    ACK_1    = 2'd1,
    ACK_GAP  = 2'd2,
    ACK_2    = 2'd3
  } ack_state_t;

  localparam logic [2:0] OCW2_ROT_AEOI_CLR = 3'b000;
  localparam logic [2:0] OCW2_NS_EOI       = 3'b001;
  localparam logic [2:0] OCW2_NOP          = 3'b010;
  localparam logic [2:0] OCW2_SP_EOI       = 3'b011;
  localparam logic [2:0] OCW2_ROT_AEOI_SET = 3'b100;
  localparam logic [2:0] OCW2_ROT_NS_EOI   = 3'b101;
  localparam logic [2:0] OCW2_SET_PRI      = 3'b110;
  localparam logic [2:0] OCW2_ROT_SP_EOI   = 3'b111;

  localparam int ICW1_LTIM_BIT = 3;
  localparam int ICW4_AEOI_BIT = 1;
  localparam int OCW3_RR_BIT   = 1;
  localparam int OCW3_RIS_BIT  = 0;

  // Rank 0 is the highest priority level, i.e. the one just after lp.
  function automatic logic [2:0] prio_rank(input logic [2:0] level, input logic [2:0] lp);
    return level - lp - 3'd1;
  endfunction

endpackage

// File: rtl/pic_interrupt_controller_resolver.sv
// Combinational priority resolver: scans from level lp+1 (highest) round to lp
// (lowest) and returns the first set request level.
module pic_priority_resolver
  import pic_interrupt_controller_pkg::*;
(
  input  logic [7:0] req,
  input  logic [2:0] lp,
  output logic [2:0] level,
  output logic       valid
);

  logic [2:0] cand;

  always_comb begin
    level = 3'd7;
    valid = 1'b0;
    cand  = 3'd0;
    for (int i = 0; i < 8; i++) begin
      cand = lp + 3'd1 + 3'(i);
      if (req[cand] && !valid) begin
        level = cand;
        valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pic_interrupt_controller.sv
// 8259A-style control core: IRR/ISR/IMR, fixed/rotating priority, 8086 INTA
// handshake with vector drive, and EOI/AEOI handling.
//
// state    | meaning
// ACK_IDLE | no acknowledge in progress
// ACK_1    | first INTA low seen; winner latched into ISR
// ACK_GAP  | between the two INTA pulses
// ACK_2    | second INTA low; vector driven
module pic_interrupt_controller
  import pic_interrupt_controller_pkg::*;
#(
  parameter int         NUM_IR    = 8,
  parameter logic [7:0] RESET_IMR = 8'hFF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        wr_data,
  input  logic              icw1_wr,
  input  logic              icw2_wr,
  input  logic              icw4_wr,
  input  logic              ocw1_wr,
  input  logic              ocw2_wr,
  input  logic              ocw3_wr,
  input  logic [NUM_IR-1:0] ir_req,
  input  logic              inta_n,
  output logic              int_out,
  output logic [7:0]        vector,
  output logic              vector_oe,
  output logic [NUM_IR-1:0] irr,
  output logic [NUM_IR-1:0] isr,
  output logic [NUM_IR-1:0] imr,
  output logic [1:0]        read_sel
);

  ack_state_t ack_state, ack_next;
  logic [7:0] prev_req, pend, irr_set, irr_lvl_clr, ack_set, eoi_clr, aeoi_clr;
  logic [2:0] lp, lp_nxt, w_lvl, pend_lvl, isr_lvl, ocw2_l;
  logic [4:0] base;
  logic       ltim, aeoi, rot_aeoi, rot_aeoi_nxt, armed, inta_prev;
  logic       pend_vld, isr_vld, win_ok, inta_fall, inta_rise;
  logic       ack1_take, ack2_enter, ack2_exit;

  assign pend      = irr & ~imr;
  assign inta_fall = inta_prev & ~inta_n;
  assign inta_rise = ~inta_prev & inta_n;
  assign ocw2_l    = wr_data[2:0];

  pic_priority_resolver u_pend_res (.req(pend), .lp(lp), .level(pend_lvl), .valid(pend_vld));
  pic_priority_resolver u_isr_res  (.req(isr),  .lp(lp), .level(isr_lvl),  .valid(isr_vld));

  assign win_ok = armed && pend_vld &&
                  (!isr_vld || (prio_rank(pend_lvl, lp) < prio_rank(isr_lvl, lp)));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ack_state <= ACK_IDLE;
    else        ack_state <= ack_next;
  end

  always_comb begin
    ack_next   = ack_state;
    ack1_take  = 1'b0;
    ack2_enter = 1'b0;
    ack2_exit  = 1'b0;
    if (icw1_wr) begin
      ack_next = ACK_IDLE;
    end else begin
      unique case (ack_state)
        ACK_IDLE: if (inta_fall) begin ack_next = ACK_1;    ack1_take  = 1'b1; end
        ACK_1:    if (inta_rise) ack_next = ACK_GAP;
        ACK_GAP:  if (inta_fall) begin ack_next = ACK_2;    ack2_enter = 1'b1; end
        ACK_2:    if (inta_rise) begin ack_next = ACK_IDLE; ack2_exit  = 1'b1; end
        default:  ack_next = ACK_IDLE;
      endcase
    end
  end

  assign ack_set     = (ack1_take && win_ok) ? (8'b1 << pend_lvl) : 8'h00;
  assign irr_set     = ltim ? ir_req : (ir_req & ~prev_req);
  assign irr_lvl_clr = ltim ? ~ir_req : 8'h00;
  assign aeoi_clr    = (ack2_exit && aeoi) ? (8'b1 << w_lvl) : 8'h00;

  // OCW2 overrides an AEOI rotation landing in the same cycle.
  always_comb begin
    eoi_clr      = 8'h00;
    lp_nxt       = lp;
    rot_aeoi_nxt = rot_aeoi;
    if (ack2_exit && aeoi && rot_aeoi) lp_nxt = w_lvl;
    if (ocw2_wr) begin
      case (wr_data[7:5])
        OCW2_NS_EOI:       if (isr_vld) eoi_clr = 8'b1 << isr_lvl;
        OCW2_SP_EOI:       eoi_clr = 8'b1 << ocw2_l;
        OCW2_ROT_NS_EOI:   if (isr_vld) begin eoi_clr = 8'b1 << isr_lvl; lp_nxt = isr_lvl; end
        OCW2_ROT_SP_EOI:   begin eoi_clr = 8'b1 << ocw2_l; lp_nxt = ocw2_l; end
        OCW2_SET_PRI:      lp_nxt = ocw2_l;
        OCW2_ROT_AEOI_SET: rot_aeoi_nxt = 1'b1;
        OCW2_ROT_AEOI_CLR: rot_aeoi_nxt = 1'b0;
        OCW2_NOP:          ;
        default:           ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irr       <= 8'h00;
      isr       <= 8'h00;
      imr       <= RESET_IMR;
      prev_req  <= 8'h00;
      lp        <= 3'd7;
      ltim      <= 1'b0;
      aeoi      <= 1'b0;
      rot_aeoi  <= 1'b0;
      base      <= 5'd0;
      armed     <= 1'b0;
      inta_prev <= 1'b1;
      w_lvl     <= 3'd0;
      int_out   <= 1'b0;
      vector    <= 8'h00;
      vector_oe <= 1'b0;
    end else begin
      inta_prev <= inta_n;
      if (icw1_wr) begin
        irr       <= 8'h00;
        isr       <= 8'h00;
        imr       <= 8'h00;
        prev_req  <= 8'h00;
        lp        <= 3'd7;
        ltim      <= wr_data[ICW1_LTIM_BIT];
        aeoi      <= 1'b0;
        armed     <= 1'b0;
        int_out   <= 1'b0;
        vector_oe <= 1'b0;
      end else begin
        prev_req <= ir_req;
        irr      <= ((irr | irr_set) & ~irr_lvl_clr) & ~ack_set;
        isr      <= (isr & ~eoi_clr & ~aeoi_clr) | ack_set;
        lp       <= lp_nxt;
        rot_aeoi <= rot_aeoi_nxt;
        int_out  <= win_ok && !ack1_take;
        if (icw2_wr) begin base <= wr_data[7:3]; armed <= 1'b1; end
        if (icw4_wr) aeoi <= wr_data[ICW4_AEOI_BIT];
        if (ocw1_wr) imr <= wr_data;
        if (ack1_take) w_lvl <= win_ok ? pend_lvl : 3'd7;
        if (ack2_enter) begin
          vector    <= {base, w_lvl};
          vector_oe <= 1'b1;
        end else if (ack2_exit) begin
          vector_oe <= 1'b0;
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) read_sel <= 2'b10;
    else if (ocw3_wr && wr_data[OCW3_RR_BIT]) read_sel <= {1'b1, wr_data[OCW3_RIS_BIT]};
  end

endmodule

// File: tb/tb_pic_interrupt_controller.sv
// Self-checking bench: table of priority/vector cases plus hand sequences for
// nesting, AEOI rotation, spurious acknowledge and mid-sequence abort.
module tb_pic_interrupt_controller;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [7:0] wr_data = 8'h00;
  logic       icw1_wr = 1'b0, icw2_wr = 1'b0, icw4_wr = 1'b0;
  logic       ocw1_wr = 1'b0, ocw2_wr = 1'b0, ocw3_wr = 1'b0;
  logic [7:0] ir_req = 8'h00;
  logic       inta_n = 1'b1;
  logic       int_out, vector_oe;
  logic [7:0] vector, irr, isr, imr;
  logic [1:0] read_sel;

  pic_interrupt_controller dut (
    .clk(clk), .rst_n(rst_n), .wr_data(wr_data),
    .icw1_wr(icw1_wr), .icw2_wr(icw2_wr), .icw4_wr(icw4_wr),
    .ocw1_wr(ocw1_wr), .ocw2_wr(ocw2_wr), .ocw3_wr(ocw3_wr),
    .ir_req(ir_req), .inta_n(inta_n), .int_out(int_out),
    .vector(vector), .vector_oe(vector_oe),
    .irr(irr), .isr(isr), .imr(imr), .read_sel(read_sel)
  );

  always #5 clk = ~clk;

  localparam int S_IRR = 0, S_ISR = 1, S_IMR = 2, S_INT = 3, S_VEC = 4, S_OE = 5, S_RSEL = 6;
  localparam int W_ICW1 = 1, W_ICW2 = 2, W_ICW4 = 4, W_OCW1 = 5, W_OCW2 = 6, W_OCW3 = 7;

  typedef struct {
    string      name;
    int         sig;
    logic [7:0] exp;
  } sb_t;

  typedef struct {
    logic [7:0] base, imr, req;
    logic [2:0] lp;
    logic       int_exp;
    logic [7:0] isr_exp, irr_exp, vec_exp;
  } vec_t;

  sb_t  q[$];
  vec_t tbl[8];
  int   checks = 0;
  int   passed = 0;

  function automatic logic [7:0] observe(input int sig);
    case (sig)
      S_IRR:   return irr;
      S_ISR:   return isr;
      S_IMR:   return imr;
      S_INT:   return {7'd0, int_out};
      S_VEC:   return vector;
      S_OE:    return {7'd0, vector_oe};
      default: return {6'd0, read_sel};
    endcase
  endfunction

  task automatic expect_val(input string name, input int sig, input logic [7:0] e);
    sb_t item;
    item.name = name;
    item.sig  = sig;
    item.exp  = e;
    q.push_back(item);
  endtask

  task automatic drain();
    sb_t        item;
    logic [7:0] act;
    while (q.size() > 0) begin
      item = q.pop_front();
      act  = observe(item.sig);
      checks++;
      if (act === item.exp) passed++;
      else $display("FAIL %s: got %02h expected %02h", item.name, act, item.exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic wr(input int which, input logic [7:0] d);
    wr_data = d;
    case (which)
      W_ICW1:  icw1_wr = 1'b1;
      W_ICW2:  icw2_wr = 1'b1;
      W_ICW4:  icw4_wr = 1'b1;
      W_OCW1:  ocw1_wr = 1'b1;
      W_OCW2:  ocw2_wr = 1'b1;
      default: ocw3_wr = 1'b1;
    endcase
    tick();
    {icw1_wr, icw2_wr, icw4_wr, ocw1_wr, ocw2_wr, ocw3_wr} = 6'b0;
  endtask

  task automatic setup(input logic [7:0] icw1, input logic [7:0] base,
                       input logic [7:0] icw4, input logic [7:0] mask);
    wr(W_ICW1, icw1);
    wr(W_ICW2, base);
    wr(W_ICW4, icw4);
    wr(W_OCW1, mask);
  endtask

  task automatic full_inta(input string tag, input logic [7:0] isr1, input logic [7:0] irr1,
                           input logic [7:0] vec, input logic [7:0] isr_end);
    inta_n = 1'b0;
    expect_val({tag, "_isr_ack1"}, S_ISR, isr1);
    expect_val({tag, "_irr_ack1"}, S_IRR, irr1);
    expect_val({tag, "_int_ack1"}, S_INT, 8'h00);
    tick();
    inta_n = 1'b1;
    tick();
    inta_n = 1'b0;
    expect_val({tag, "_vec"}, S_VEC, vec);
    expect_val({tag, "_oe_ack2"}, S_OE, 8'h01);
    tick();
    inta_n = 1'b1;
    expect_val({tag, "_oe_end"}, S_OE, 8'h00);
    expect_val({tag, "_isr_end"}, S_ISR, isr_end);
    tick();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //            base   imr    req    lp    int   isr    irr    vector
    tbl[0] = '{8'h40, 8'h00, 8'h08, 3'd7, 1'b1, 8'h08, 8'h00, 8'h43};
    tbl[1] = '{8'h40, 8'h00, 8'h21, 3'd4, 1'b1, 8'h20, 8'h01, 8'h45};
    tbl[2] = '{8'h40, 8'h00, 8'h21, 3'd7, 1'b1, 8'h01, 8'h20, 8'h40};
    tbl[3] = '{8'h40, 8'h01, 8'h21, 3'd7, 1'b1, 8'h20, 8'h01, 8'h45};
    tbl[4] = '{8'h40, 8'h00, 8'h81, 3'd6, 1'b1, 8'h80, 8'h01, 8'h47};
    tbl[5] = '{8'h40, 8'h10, 8'h10, 3'd7, 1'b0, 8'h00, 8'h10, 8'h47};
    tbl[6] = '{8'h40, 8'h00, 8'hFF, 3'd2, 1'b1, 8'h08, 8'hF7, 8'h43};
    tbl[7] = '{8'hA8, 8'h00, 8'h06, 3'd0, 1'b1, 8'h02, 8'h04, 8'hA9};

    // Reset values
    repeat (2) @(posedge clk);
    #1;
    expect_val("rst_irr", S_IRR, 8'h00);
    expect_val("rst_isr", S_ISR, 8'h00);
    expect_val("rst_imr", S_IMR, 8'hFF);
    expect_val("rst_int", S_INT, 8'h00);
    expect_val("rst_vec", S_VEC, 8'h00);
    expect_val("rst_oe", S_OE, 8'h00);
    expect_val("rst_rsel", S_RSEL, 8'h02);
    drain();
    rst_n = 1'b1;
    tick();

    // OCW3 read select
    expect_val("ocw3_isr", S_RSEL, 8'h03);
    wr(W_OCW3, 8'h0B);
    expect_val("ocw3_norr", S_RSEL, 8'h03);
    wr(W_OCW3, 8'h08);
    expect_val("ocw3_irr", S_RSEL, 8'h02);
    wr(W_OCW3, 8'h0A);

    // Basic flow with mask drop and nonspecific EOI
    setup(8'h13, 8'h40, 8'h01, 8'h00);
    ir_req = 8'h08;
    expect_val("basic_irr", S_IRR, 8'h08);
    tick();
    expect_val("basic_int", S_INT, 8'h01);
    tick();
    wr(W_OCW1, 8'h08);
    expect_val("mask_int_drop", S_INT, 8'h00);
    tick();
    wr(W_OCW1, 8'h00);
    expect_val("unmask_int", S_INT, 8'h01);
    tick();
    full_inta("basic", 8'h08, 8'h00, 8'h43, 8'h08);
    expect_val("basic_eoi", S_ISR, 8'h00);
    wr(W_OCW2, 8'h20);

    // Priority / vector table
    for (int i = 0; i < 8; i++) begin
      ir_req = 8'h00;
      tick();
      setup(8'h13, tbl[i].base, 8'h01, tbl[i].imr);
      wr(W_OCW2, {5'b11000, tbl[i].lp});
      ir_req = tbl[i].req;
      expect_val($sformatf("v%0d_irr", i), S_IRR, tbl[i].req);
      tick();
      expect_val($sformatf("v%0d_int", i), S_INT, {7'd0, tbl[i].int_exp});
      tick();
      full_inta($sformatf("v%0d", i), tbl[i].isr_exp, tbl[i].irr_exp, tbl[i].vec_exp, tbl[i].isr_exp);
    end

    // Nesting: IR2 over ISR5; IR7 blocked by ISR5
    ir_req = 8'h00;
    tick();
    setup(8'h13, 8'h40, 8'h01, 8'h00);
    ir_req = 8'h20;
    tick();
    expect_val("nest_int5", S_INT, 8'h01);
    tick();
    full_inta("nest5", 8'h20, 8'h00, 8'h45, 8'h20);
    ir_req = 8'h24;
    expect_val("nest_irr2", S_IRR, 8'h04);
    tick();
    expect_val("nest_int2", S_INT, 8'h01);
    tick();
    full_inta("nest2", 8'h24, 8'h00, 8'h42, 8'h24);
    expect_val("nest_nseoi", S_ISR, 8'h20);
    wr(W_OCW2, 8'h20);
    ir_req = 8'hA4;
    expect_val("nest_irr7", S_IRR, 8'h80);
    tick();
    expect_val("nest_int7_a", S_INT, 8'h00);
    tick();
    expect_val("nest_int7_b", S_INT, 8'h00);
    tick();
    expect_val("nest_speoi", S_ISR, 8'h00);
    wr(W_OCW2, 8'h65);
    expect_val("nest_int7_go", S_INT, 8'h01);
    tick();

    // AEOI with rotation: lp follows the acknowledged level
    ir_req = 8'h00;
    tick();
    setup(8'h13, 8'h40, 8'h03, 8'h00);
    wr(W_OCW2, 8'h80);
    ir_req = 8'h08;
    tick();
    expect_val("aeoi_int", S_INT, 8'h01);
    tick();
    full_inta("aeoi3", 8'h08, 8'h00, 8'h43, 8'h00);
    ir_req = 8'h1C;
    expect_val("aeoi_irr", S_IRR, 8'h14);
    tick();
    tick();
    full_inta("aeoi_rot", 8'h10, 8'h04, 8'h44, 8'h00);

    // Spurious acknowledge in level mode
    ir_req = 8'h00;
    tick();
    setup(8'h1B, 8'h40, 8'h01, 8'h00);
    ir_req = 8'h08;
    expect_val("spur_irr", S_IRR, 8'h08);
    tick();
    expect_val("spur_int", S_INT, 8'h01);
    tick();
    ir_req = 8'h00;
    expect_val("spur_irr_drop", S_IRR, 8'h00);
    tick();
    full_inta("spur", 8'h00, 8'h00, 8'h47, 8'h00);

    // ICW1 between INTA pulses
    setup(8'h13, 8'h40, 8'h01, 8'h00);
    ir_req = 8'h08;
    tick();
    expect_val("abort_int", S_INT, 8'h01);
    tick();
    inta_n = 1'b0;
    expect_val("abort_isr", S_ISR, 8'h08);
    tick();
    inta_n = 1'b1;
    tick();
    expect_val("abort_icw1_isr", S_ISR, 8'h00);
    wr(W_ICW1, 8'h13);
    inta_n = 1'b0;
    expect_val("abort_oe_a", S_OE, 8'h00);
    tick();
    inta_n = 1'b1;
    expect_val("abort_oe_b", S_OE, 8'h00);
    expect_val("abort_int_b", S_INT, 8'h00);
    expect_val("abort_isr_b", S_ISR, 8'h00);
    tick();

    // Reset between INTA pulses
    setup(8'h13, 8'h40, 8'h01, 8'h00);
    expect_val("rstmid_int", S_INT, 8'h01);
    tick();
    inta_n = 1'b0;
    expect_val("rstmid_isr", S_ISR, 8'h08);
    tick();
    inta_n = 1'b1;
    tick();
    rst_n = 1'b0;
    #3;
    expect_val("rstmid_isr0", S_ISR, 8'h00);
    expect_val("rstmid_imr", S_IMR, 8'hFF);
    expect_val("rstmid_int0", S_INT, 8'h00);
    drain();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    inta_n = 1'b0;
    expect_val("rstmid_oe_a", S_OE, 8'h00);
    tick();
    inta_n = 1'b1;
    expect_val("rstmid_oe_b", S_OE, 8'h00);
    expect_val("rstmid_int_b", S_INT, 8'h00);
    tick();

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
